// File: rtl/lifo_pkg.sv
// ---------------------------------------------------------------------------
// lifo_pkg
//   Shared definitions for the lifo block and its read-side streamer.
//   - LIFO_AWIDTH / LIFO_DEPTH : default geometry shared with lifo and benches
//   - rd_state_t               : read streamer FSM states
//   - credit_sum()             : buffered + in-flight word count
// ---------------------------------------------------------------------------
package lifo_pkg;

    localparam int LIFO_AWIDTH = 4;
    localparam int LIFO_DEPTH  = 2**LIFO_AWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        FLUSH,
        DONE
    } rd_state_t;

    // Words already committed to the output buffer: stored plus the one
    // whose read data arrives this cycle.
    function automatic logic [1:0] credit_sum(input logic [1:0] occ,
                                              input logic       inflight);
        return occ + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/lifo_rd_skid.sv
// ---------------------------------------------------------------------------
// lifo_rd_skid
//   Two-entry FIFO holding data words and their last tags between the LIFO
//   read port and the output stream.
// Ports
//   clk_i, srst_i      clock, synchronous active-high reset
//   push_i             write push_data_i/push_last_i into the tail
//   pop_i              drop the head entry
//   mark_last_i        set the last tag of the current tail entry
//   head_data_o/last_o head entry (last is masked while empty)
//   occ_o              number of stored entries (0..2)
//   full_o, empty_o    occupancy flags
// ---------------------------------------------------------------------------
module lifo_rd_skid #(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    input  logic              mark_last_i,
    output logic [DWIDTH-1:0] head_data_o,
    output logic              head_last_o,
    output logic [1:0]        occ_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DWIDTH-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            data_q <= '{default: '0};
            last_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            // Tail is the entry written most recently, one behind wr_ptr.
            if (mark_last_i) begin
                last_q[~wr_ptr] <= 1'b1;
            end
            if (push_i) begin
                data_q[wr_ptr] <= push_data_i;
                last_q[wr_ptr] <= push_last_i;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop_i) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_i, pop_i})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data_o = data_q[rd_ptr];
    assign head_last_o = last_q[rd_ptr] & (occ != 2'd0);
    assign occ_o       = occ;
    assign full_o      = (occ == 2'd2);
    assign empty_o     = (occ == 2'd0);

endmodule

// File: rtl/lifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// lifo_rd_streamer
//   Pops a burst of words from a LIFO read port on start_i and presents them
//   as a valid/ready stream with a last flag. The LIFO's 1-cycle read latency
//   and downstream backpressure are absorbed by a 2-entry output buffer.
// Ports
//   clk_i, srst_i        clock, synchronous active-high reset
//   start_i, len_i       burst request (sampled in IDLE); len 0 = drain all
//   busy_o, done_o       burst in progress / 1-cycle completion pulse
//   popped_o             words popped in the current/last burst
//   rdreq_o              LIFO pop request
//   q_i, empty_i, usedw_i LIFO read data, empty flag, fill level
//   m_data_o, m_valid_o, m_last_o, m_ready_i  output stream
// ---------------------------------------------------------------------------
module lifo_rd_streamer
    import lifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = LIFO_AWIDTH
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AWIDTH:0]   popped_o,
    output logic              rdreq_o,
    input  logic [DWIDTH-1:0] q_i,
    input  logic              empty_i,
    input  logic [AWIDTH:0]   usedw_i,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);

    localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

    rd_state_t       state;
    logic [AWIDTH:0] remaining;
    logic            len_mode;
    logic            last_issued;
    logic            inflight;
    logic            inflight_last;
    logic            busy_q;
    logic            done_q;
    logic [AWIDTH:0] popped_q;

    logic [1:0]      occ;
    logic            skid_full;
    logic            skid_empty;
    logic            head_last;
    logic            skid_push;
    logic            push_last;

    logic            xfer;
    logic [1:0]      committed;
    logic            credit_ok;
    logic            issue;
    logic            issue_last;
    logic            starved;
    logic            force_last;
    logic            mark_tail;
    logic            starve_done;

    assign xfer      = m_valid_o && m_ready_i;
    assign committed = credit_sum(occ, inflight);
    // A buffer slot freed by this cycle's transfer may be re-used at once,
    // which keeps one word per clock flowing with m_ready_i held high.
    assign credit_ok = (committed < 2'd2) || ((committed == 2'd2) && xfer);

    assign issue      = (state == POP) && !empty_i && credit_ok && !last_issued;
    assign issue_last = (len_mode && (remaining == CNT_ONE)) || (usedw_i == CNT_ONE);

    // LIFO ran dry before the burst's last word was tagged: the newest word
    // still on its way becomes last; failing that the buffer tail; failing
    // that (buffer emptying now) the burst ends with no last flag.
    assign starved     = (state == POP) && empty_i && !last_issued;
    assign force_last  = starved && inflight;
    assign mark_tail   = starved && !inflight && !skid_empty &&
                         !((occ == 2'd1) && xfer);
    assign starve_done = starved && !inflight && !mark_tail;

    // Buffer never overflows by construction of credit_ok; the gate is a
    // defensive guard only.
    assign skid_push = inflight && (!skid_full || xfer);
    assign push_last = inflight_last || force_last;

    lifo_rd_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .push_i      (skid_push),
        .push_data_i (q_i),
        .push_last_i (push_last),
        .pop_i       (xfer),
        .mark_last_i (mark_tail),
        .head_data_o (m_data_o),
        .head_last_o (head_last),
        .occ_o       (occ),
        .full_o      (skid_full),
        .empty_o     (skid_empty)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state         <= IDLE;
            remaining     <= '0;
            len_mode      <= 1'b0;
            last_issued   <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            popped_q      <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && issue_last;

            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        popped_q    <= '0;
                        remaining   <= len_i;
                        len_mode    <= (len_i != '0);
                        last_issued <= 1'b0;
                        if (empty_i) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= POP;
                            busy_q <= 1'b1;
                        end
                    end
                end

                POP: begin
                    if (issue) begin
                        popped_q <= popped_q + CNT_ONE;
                        if (len_mode) begin
                            remaining <= remaining - CNT_ONE;
                        end
                        if (issue_last) begin
                            last_issued <= 1'b1;
                            state       <= FLUSH;
                        end
                    end else if (starved) begin
                        last_issued <= 1'b1;
                        if (starve_done) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (xfer && head_last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rdreq_o   = issue;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign popped_o  = popped_q;
    assign m_valid_o = !skid_empty;
    assign m_last_o  = head_last;

endmodule

// File: tb/tb_lifo_rd_streamer.sv
// ---------------------------------------------------------------------------
// tb_lifo_rd_streamer
//   Drives lifo_rd_streamer against a behavioural LIFO (DWIDTH=8, AWIDTH=4).
//   Expected words are queued from the LIFO contents when a burst starts and
//   compared as the stream transfers them.
// ---------------------------------------------------------------------------
module tb_lifo_rd_streamer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       srst;
    logic       start;
    logic [4:0] len;
    logic       busy, done, rdreq;
    logic [4:0] popped;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_ready;

    // behavioural LIFO
    logic [7:0] lf_mem [16];
    int         lf_cnt = 0;
    logic [7:0] lf_q   = '0;
    logic       lf_wr;
    logic [7:0] lf_wd;
    logic       lf_empty;
    logic [4:0] lf_usedw;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   nxfer = 0;
    int   last_xfer_cyc = 0;
    int   first_cyc = 0;
    bit   first_pending = 0;
    bit   toggle = 0;
    int   bocc = 0;
    int   binfl = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign lf_empty = (lf_cnt == 0);
    assign lf_usedw = 5'(lf_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lf_wr && lf_cnt < 16) begin
            lf_mem[lf_cnt] <= lf_wd;
            lf_cnt         <= lf_cnt + 1;
        end else if (rdreq && lf_cnt != 0) begin
            lf_q   <= lf_mem[lf_cnt-1];
            lf_cnt <= lf_cnt - 1;
        end
    end

    lifo_rd_streamer #(.DWIDTH(8), .AWIDTH(4)) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .start_i   (start),
        .len_i     (len),
        .busy_o    (busy),
        .done_o    (done),
        .popped_o  (popped),
        .rdreq_o   (rdreq),
        .q_i       (lf_q),
        .empty_i   (lf_empty),
        .usedw_i   (lf_usedw),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_last_o  (m_last),
        .m_ready_i (m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor plus an occupancy model built only from port activity.
    always @(negedge clk) begin
        int   xf;
        exp_t e;
        if (srst) begin
            bocc  = 0;
            binfl = 0;
        end else begin
            xf = (m_valid && m_ready) ? 1 : 0;
            if (m_valid || bocc != 0)
                chk("valid_vs_occ", 32'(m_valid), 32'(bocc != 0));
            if (rdreq) begin
                chk("rdreq_while_empty", 32'(lf_empty), 32'd0);
                chk("rdreq_credit", 32'(bocc + binfl + 1 - xf <= 2), 32'd1);
            end
            if (xf != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", 32'(m_data), 32'(e.data));
                    chk("word_last", 32'(m_last), 32'(e.last));
                end
                if (first_pending) begin
                    first_cyc     = cyc;
                    first_pending = 0;
                end
                last_xfer_cyc = cyc;
                nxfer++;
            end
            bocc  = bocc + binfl - xf;
            binfl = rdreq ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        lf_wr = 1'b1;
        lf_wd = d;
        tick();
        lf_wr = 1'b0;
    endtask

    task automatic expect_burst(input int n);
        int k;
        exp_t e;
        k = (n == 0 || n > lf_cnt) ? lf_cnt : n;
        for (int j = 0; j < k; j++) begin
            e.data = lf_mem[lf_cnt-1-j];
            e.last = (j == k - 1);
            sb.push_back(e);
        end
    endtask

    task automatic start_burst(input int n, input bit exp_busy);
        start = 1'b1;
        len   = 5'(n);
        tick();
        start = 1'b0;
        if (exp_busy) chk("busy_after_start", 32'(busy), 32'd1);
        else          chk("done_immediate", 32'(done), 32'd1);
    endtask

    task automatic wait_done(input bit check_gap);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (toggle) m_ready = ~m_ready;
            tick();
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("busy_in_done", 32'(busy), 32'd0);
            if (check_gap) chk("done_after_last", 32'(cyc), 32'(last_xfer_cyc + 1));
            tick();
            chk("done_one_cycle", 32'(done), 32'd0);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_done",   32'(done),    32'd0);
        chk("rst_rdreq",  32'(rdreq),   32'd0);
        chk("rst_valid",  32'(m_valid), 32'd0);
        chk("rst_last",   32'(m_last),  32'd0);
        chk("rst_popped", 32'(popped),  32'd0);
        chk("rst_data",   32'(m_data),  32'd0);
    endtask

    initial begin
        int base;
        srst    = 1'b1;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b1;
        lf_wr   = 1'b0;
        lf_wd   = '0;
        repeat (3) tick();
        chk_reset_outputs();
        srst = 1'b0;
        tick();

        // len=3 out of five stacked words
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        expect_burst(3);
        start_burst(3, 1);
        wait_done(1);
        chk("t1_popped", 32'(popped), 32'd3);
        chk("t1_usedw", 32'(lf_usedw), 32'd2);

        // drain what is left
        expect_burst(0);
        start_burst(0, 1);
        wait_done(1);
        chk("t1b_popped", 32'(popped), 32'd2);

        // full LIFO drain, ready held high
        for (int i = 0; i < 16; i++) push(8'(i));
        expect_burst(0);
        first_pending = 1;
        start_burst(0, 1);
        wait_done(1);
        chk("t2_popped", 32'(popped), 32'd16);
        chk("t2_rate", 32'(last_xfer_cyc - first_cyc), 32'd15);
        chk("t2_usedw", 32'(lf_usedw), 32'd0);

        // full LIFO drain with ready toggling
        for (int i = 0; i < 16; i++) push(8'(i));
        expect_burst(0);
        toggle = 1;
        start_burst(0, 1);
        wait_done(1);
        toggle  = 0;
        m_ready = 1'b1;
        chk("t3_popped", 32'(popped), 32'd16);

        // len larger than contents
        push(8'hA0);
        push(8'hA1);
        expect_burst(5);
        start_burst(5, 1);
        wait_done(1);
        chk("t4_popped", 32'(popped), 32'd2);
        chk("t4_usedw", 32'(lf_usedw), 32'd0);

        // empty LIFO
        expect_burst(4);
        start_burst(4, 0);
        wait_done(0);
        chk("t5_popped", 32'(popped), 32'd0);

        // reset after three words
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        expect_burst(0);
        base = nxfer;
        start_burst(0, 1);
        for (int i = 0; i < 100; i++) begin
            if (nxfer >= base + 3) break;
            tick();
        end
        chk("t6_three_words", 32'(nxfer >= base + 3), 32'd1);
        srst = 1'b1;
        tick();
        chk_reset_outputs();
        sb.delete();
        srst = 1'b0;
        tick();
        expect_burst(0);
        start_burst(0, lf_cnt != 0);
        wait_done(lf_cnt != 0);
        chk("t6_usedw", 32'(lf_usedw), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
